// File: rtl/game_screen_sequencer_if.sv
// Screen-sequencer bus: raw buttons, engine events, per-screen pixel sources and sequencer status.
// master = the surrounding breakout design, slave = game_screen_sequencer.
interface game_screen_sequencer_if;
  logic        start_btn;
  logic        pause_btn;
  logic        frame_tick;
  logic        game_win;
  logic        game_lose;
  logic [15:0] start_data;
  logic [15:0] play_data;
  logic [15:0] win_data;
  logic [15:0] lose_data;
  logic [15:0] pix_data;
  logic        game_active;
  logic        game_restart;
  logic        respawn;
  logic [3:0]  lives_left;
  logic [2:0]  state_code;
  logic [2:0]  state_leds;

  modport master (
    output start_btn, pause_btn, frame_tick, game_win, game_lose,
    output start_data, play_data, win_data, lose_data,
    input  pix_data, game_active, game_restart, respawn, lives_left, state_code, state_leds
  );

  modport slave (
    input  start_btn, pause_btn, frame_tick, game_win, game_lose,
    input  start_data, play_data, win_data, lose_data,
    output pix_data, game_active, game_restart, respawn, lives_left, state_code, state_leds
  );
endinterface

// File: rtl/game_screen_sequencer.sv
// Breakout screen flow: debounced start/pause, six-state game FSM, lives, pixel select/dim (SCREEN_AUTO_RETURN_EN adds timed WIN/LOSE exit).
// Latency: state and status outputs 1 cycle after the event, pix_data 1 cycle after the state; button press 2+DEBOUNCE_CYC+1 cycles.
// Backpressure: none; events are single-cycle pulses sampled every vga_clk cycle.
module game_screen_sequencer #(
  parameter int DEBOUNCE_CYC       = 100000,
  parameter int LIVES              = 3,
  parameter int RESPAWN_FRAMES     = 60,
  parameter int AUTO_RETURN_FRAMES = 600
) (
  input logic                    vga_clk,
  input logic                    sys_rst_n,
  game_screen_sequencer_if.slave scr
);

  if (DEBOUNCE_CYC < 2 || LIVES < 1 || LIVES > 15 || RESPAWN_FRAMES < 1 || AUTO_RETURN_FRAMES < 1) begin : g_bad_cfg
    $error("game_screen_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {
    ST_START     = 3'd0,
    ST_PLAY      = 3'd1,
    ST_PAUSE     = 3'd2,
    ST_LIFE_LOST = 3'd3,
    ST_WIN       = 3'd4,
    ST_LOSE      = 3'd5
  } state_t;

  localparam logic [19:0] CNT_LAST   = 20'(DEBOUNCE_CYC - 1);
  localparam logic [15:0] RESP_LAST  = 16'(RESPAWN_FRAMES - 1);
  localparam logic [3:0]  LIVES_INIT = 4'(LIVES);
`ifdef SCREEN_AUTO_RETURN_EN
  localparam logic [15:0] AUTO_LAST  = 16'(AUTO_RETURN_FRAMES - 1);
`endif

  // Index 0 = start button, 1 = pause button; all button levels are active-low.
  logic [1:0]  raw_btn, sync1, sync2, deb, deb_d, press;
  logic [19:0] deb_cnt [2];
  logic        start_press, pause_press;

  assign raw_btn     = {scr.pause_btn, scr.start_btn};
  assign start_press = press[0];
  assign pause_press = press[1];

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      deb_d <= '1;
      press <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw_btn;
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb_d & ~deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 20'd1;
        end
      end
    end
  end

  logic [2:0]  state;
  state_t      nxt_state;
  logic [3:0]  nxt_lives;
  logic        nxt_restart, nxt_respawn;
  logic [2:0]  nxt_leds;
  logic [15:0] frame_cnt;
  logic [15:0] pix_sel;

  always_comb begin
    nxt_state   = ST_START;
    nxt_lives   = scr.lives_left;
    nxt_restart = 1'b0;
    nxt_respawn = 1'b0;
    case (state)
      ST_START: begin
        if (start_press) begin
          nxt_state   = ST_PLAY;
          nxt_restart = 1'b1;
          nxt_lives   = LIVES_INIT;
        end else begin
          nxt_state = ST_START;
        end
      end
      ST_PLAY: begin
        if (scr.game_win) begin
          nxt_state = ST_WIN;
        end else if (scr.game_lose) begin
          if (scr.lives_left > 4'd1) begin
            nxt_state = ST_LIFE_LOST;
            nxt_lives = scr.lives_left - 4'd1;
          end else begin
            nxt_state = ST_LOSE;
            nxt_lives = 4'd0;
          end
        end else if (pause_press) begin
          nxt_state = ST_PAUSE;
        end else begin
          nxt_state = ST_PLAY;
        end
      end
      ST_PAUSE: begin
        if (start_press)      nxt_state = ST_START;
        else if (pause_press) nxt_state = ST_PLAY;
        else                  nxt_state = ST_PAUSE;
      end
      ST_LIFE_LOST: begin
        if (scr.frame_tick && frame_cnt == RESP_LAST) begin
          nxt_state   = ST_PLAY;
          nxt_respawn = 1'b1;
        end else begin
          nxt_state = ST_LIFE_LOST;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (start_press)
          nxt_state = ST_START;
`ifdef SCREEN_AUTO_RETURN_EN
        else if (scr.frame_tick && frame_cnt == AUTO_LAST)
          nxt_state = ST_START;
`endif
        else
          nxt_state = (state == ST_WIN) ? ST_WIN : ST_LOSE;
      end
      default: nxt_state = ST_START;
    endcase
  end

  always_comb begin
    nxt_leds = 3'b001;
    case (nxt_state)
      ST_START:     nxt_leds = 3'b001;
      ST_PLAY:      nxt_leds = 3'b010;
      ST_PAUSE:     nxt_leds = 3'b011;
      ST_LIFE_LOST: nxt_leds = 3'b110;
      ST_WIN:       nxt_leds = 3'b100;
      ST_LOSE:      nxt_leds = 3'b101;
      default:      nxt_leds = 3'b001;
    endcase
  end

  // PAUSE halves each RGB565 channel of the play screen.
  always_comb begin
    pix_sel = 16'h0000;
    case (state)
      ST_START:              pix_sel = scr.start_data;
      ST_PLAY, ST_LIFE_LOST: pix_sel = scr.play_data;
      ST_PAUSE:              pix_sel = {1'b0, scr.play_data[15:12], 1'b0, scr.play_data[10:6],
                                        1'b0, scr.play_data[4:1]};
      ST_WIN:                pix_sel = scr.win_data;
      ST_LOSE:               pix_sel = scr.lose_data;
      default:               pix_sel = 16'h0000;
    endcase
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state            <= ST_START;
      frame_cnt        <= '0;
      scr.state_code   <= 3'd0;
      scr.state_leds   <= 3'b001;
      scr.game_active  <= 1'b0;
      scr.game_restart <= 1'b0;
      scr.respawn      <= 1'b0;
      scr.lives_left   <= LIVES_INIT;
      scr.pix_data     <= 16'h0000;
    end else begin
      state            <= nxt_state;
      scr.state_code   <= nxt_state;
      scr.state_leds   <= nxt_leds;
      scr.game_active  <= (nxt_state == ST_PLAY);
      scr.game_restart <= nxt_restart;
      scr.respawn      <= nxt_respawn;
      scr.lives_left   <= nxt_lives;
      scr.pix_data     <= pix_sel;
      // A tick landing on a state change is dropped so the new state starts from zero.
      if (nxt_state != state)
        frame_cnt <= '0;
      else if (scr.frame_tick && frame_cnt != 16'hFFFF)
        frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule
